// File: rtl/fios_pkg.sv
// Shared codes for the FIOS modular-exponentiation controller: operand selects,
// result destinations, controller states and the per-state operation table.
package fios_pkg;

    typedef enum logic [2:0] {
        OPS_ACC  = 3'd0,
        OPS_XM   = 3'd1,
        OPS_BASE = 3'd2,
        OPS_R2   = 3'd3,
        OPS_ONE  = 3'd4
    } op_sel_t;

    typedef enum logic {
        DST_ACC = 1'b0,
        DST_XM  = 1'b1
    } dst_t;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CONV_X    = 4'd1,
        CONV_ACC  = 4'd2,
        SQUARE    = 4'd3,
        MULT      = 4'd4,
        NEXT_BIT  = 4'd5,
        FROM_MONT = 4'd6,
        WAIT      = 4'd7,
        DONE      = 4'd8
    } state_t;

    typedef struct packed {
        op_sel_t a;
        op_sel_t b;
        dst_t    dst;
    } op_cfg_t;

    localparam logic [15:0] MUL_COUNT_MAX = 16'hFFFF;

    // States that launch exactly one Montgomery multiplication on entry.
    function automatic logic is_op_state(input state_t st);
        return (st == CONV_X) || (st == CONV_ACC) || (st == SQUARE) ||
               (st == MULT)   || (st == FROM_MONT);
    endfunction

    function automatic op_cfg_t op_cfg(input state_t st);
        op_cfg_t cfg;
        cfg = '{OPS_ACC, OPS_ACC, DST_ACC};
        case (st)
            CONV_X:    cfg = '{OPS_BASE, OPS_R2,  DST_XM};
            CONV_ACC:  cfg = '{OPS_ONE,  OPS_R2,  DST_ACC};
            SQUARE:    cfg = '{OPS_ACC,  OPS_ACC, DST_ACC};
            MULT:      cfg = '{OPS_ACC,  OPS_XM,  DST_ACC};
            FROM_MONT: cfg = '{OPS_ACC,  OPS_ONE, DST_ACC};
            default:   cfg = '{OPS_ACC,  OPS_ACC, DST_ACC};
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/exp_bit_scanner.sv
// Left-to-right exponent scanner: a shift register whose MSB is the bit being
// processed, a bit index that stops at 0, and a "a 1 was already passed" flag.
module exp_bit_scanner #(
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [EXP_WIDTH-1:0] exp_value,
    input  logic                 step,
    output logic                 cur_bit,
    output logic                 next_bit,
    output logic                 last_bit,
    output logic                 one_seen,
    output logic                 exp_zero
);

    localparam int IW = $clog2(EXP_WIDTH);
    localparam logic [IW-1:0] TOP_IDX = IW'(EXP_WIDTH - 1);

    logic [EXP_WIDTH-1:0] shift_q;
    logic [IW-1:0]        idx_q;
    logic                 seen_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            idx_q   <= '0;
            seen_q  <= 1'b0;
        end else if (load) begin
            shift_q <= exp_value;
            idx_q   <= TOP_IDX;
            seen_q  <= 1'b0;
        end else if (step && (idx_q != '0)) begin
            // The index saturates at 0 so the scan can never wrap back to the MSB.
            shift_q <= {shift_q[EXP_WIDTH-2:0], 1'b0};
            idx_q   <= idx_q - 1'b1;
            seen_q  <= seen_q | shift_q[EXP_WIDTH-1];
        end
    end

    assign cur_bit  = shift_q[EXP_WIDTH-1];
    assign next_bit = shift_q[EXP_WIDTH-2];
    assign last_bit = (idx_q == '0);
    assign one_seen = seen_q;
    assign exp_zero = (shift_q == '0);

endmodule

// File: rtl/modexp_control.sv
// Sequencer for left-to-right Montgomery modular exponentiation over a FIOS multiplier.
// Optional build macro MODEXP_SKIP_LEADING_ZEROS_EN skips the work before the first 1 bit.
module modexp_control
    import fios_pkg::*;
#(
    parameter int s         = 8,
    parameter int EXP_WIDTH = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [EXP_WIDTH-1:0] exp_i,
    input  logic                 mul_done_i,
    output logic                 mul_start_o,
    output logic [2:0]           op_a_sel_o,
    output logic [2:0]           op_b_sel_o,
    output logic                 res_dst_o,
    output logic                 res_we_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [15:0]          mul_count_o,
    output state_t               dbg_state_o
);

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    localparam bit SKIP_EN = 1'b1;
`else
    localparam bit SKIP_EN = 1'b0;
`endif

    // An illegal configuration never leaves IDLE.
    localparam bit CFG_OK = (s >= 1) && (EXP_WIDTH >= 2);

    // Handshake: mul_start_o is a one-cycle launch; the multiplier answers with a
    // one-cycle mul_done_i that is honoured only in WAIT. WAIT then spends one more
    // cycle raising res_we_o so the select codes stay valid for the write-back.
    state_t  state_q, state_d;
    state_t  ret_q, ret_d;
    op_cfg_t cfg_q;
    logic    wb_q, wb_d;
    logic    step;
    logic    start_ok;
    logic [15:0] count_q;

    logic cur_bit, next_bit, last_bit, one_seen, exp_zero;

    assign start_ok = start_i && CFG_OK && ((state_q == IDLE) || (state_q == DONE));

    exp_bit_scanner #(
        .EXP_WIDTH (EXP_WIDTH)
    ) u_scanner (
        .clk       (clock_i),
        .rst       (reset_i),
        .load      (start_ok),
        .exp_value (exp_i),
        .step      (step),
        .cur_bit   (cur_bit),
        .next_bit  (next_bit),
        .last_bit  (last_bit),
        .one_seen  (one_seen),
        .exp_zero  (exp_zero)
    );

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        wb_d    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start_ok) state_d = CONV_X;
            end
            CONV_X: begin
                ret_d   = CONV_ACC;
                state_d = WAIT;
            end
            CONV_ACC: begin
                if (!SKIP_EN)      ret_d = SQUARE;
                else if (exp_zero) ret_d = FROM_MONT;
                else if (cur_bit)  ret_d = MULT;
                else               ret_d = NEXT_BIT;
                state_d = WAIT;
            end
            SQUARE: begin
                ret_d   = cur_bit ? MULT : NEXT_BIT;
                state_d = WAIT;
            end
            MULT: begin
                ret_d   = NEXT_BIT;
                state_d = WAIT;
            end
            FROM_MONT: begin
                ret_d   = DONE;
                state_d = WAIT;
            end
            NEXT_BIT: begin
                if (last_bit) begin
                    state_d = FROM_MONT;
                end else begin
                    step = 1'b1;
                    // Decide on the bit that becomes current after this shift.
                    if (!SKIP_EN || one_seen || cur_bit) state_d = SQUARE;
                    else if (next_bit)                   state_d = MULT;
                    else                                 state_d = NEXT_BIT;
                end
            end
            WAIT: begin
                if (wb_q)            state_d = ret_q;
                else if (mul_done_i) wb_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ret_q   <= IDLE;
            cfg_q   <= '0;
            wb_q    <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            wb_q    <= wb_d;
            if (is_op_state(state_d)) cfg_q <= op_cfg(state_d);
            if (start_ok)
                count_q <= '0;
            else if (mul_start_o && (count_q != MUL_COUNT_MAX))
                count_q <= count_q + 16'd1;
        end
    end

    assign mul_start_o = is_op_state(state_q);
    assign op_a_sel_o  = cfg_q.a;
    assign op_b_sel_o  = cfg_q.b;
    assign res_dst_o   = cfg_q.dst;
    assign res_we_o    = wb_q;
    assign busy_o      = (state_q != IDLE) && (state_q != DONE);
    assign done_o      = (state_q == DONE);
    assign mul_count_o = count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_modexp_control.sv
// Randomized bench for modexp_control with a behavioural multiplier and an
// expected-operation queue built from the exponent bits.
module tb_modexp_control;
    import fios_pkg::*;

    localparam int EW  = 8;
    localparam int LAT = 10;
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic [EW-1:0] exp_i   = '0;
    logic          mul_done_i;
    logic          mul_start_o, res_dst_o, res_we_o, busy_o, done_o;
    logic [2:0]    op_a_sel_o, op_b_sel_o;
    logic [15:0]   mul_count_o;
    state_t        dbg_state_o;

    logic model_done = 1'b0;
    logic extra_done = 1'b0;
    assign mul_done_i = model_done | extra_done;

    always #5 clock_i = ~clock_i;

    modexp_control #(.s(8), .EXP_WIDTH(EW)) dut (
        .clock_i     (clock_i),
        .reset_i     (reset_i),
        .start_i     (start_i),
        .exp_i       (exp_i),
        .mul_done_i  (mul_done_i),
        .mul_start_o (mul_start_o),
        .op_a_sel_o  (op_a_sel_o),
        .op_b_sel_o  (op_b_sel_o),
        .res_dst_o   (res_dst_o),
        .res_we_o    (res_we_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .mul_count_o (mul_count_o),
        .dbg_state_o (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int         n_tests = 0;
    int         n_fail  = 0;
    int         n_starts = 0;
    int         n_we = 0;
    int         cd = 0;
    bit         saw_square = 1'b0;
    logic [6:0] last_op = '0;
    logic [6:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic logic [6:0] op_code(input logic [2:0] a, input logic [2:0] b, input logic d);
        return {a, b, d};
    endfunction

    // Reference: the operation list for an exponent, straight from the bit rules.
    task automatic build_expect(input logic [EW-1:0] e);
        bit seen;
        seen = 1'b0;
        exp_q.delete();
        exp_q.push_back(op_code(OPS_BASE, OPS_R2, DST_XM));
        exp_q.push_back(op_code(OPS_ONE, OPS_R2, DST_ACC));
        for (int i = EW - 1; i >= 0; i--) begin
            if (SKIP && !seen) begin
                if (e[i]) begin
                    exp_q.push_back(op_code(OPS_ACC, OPS_XM, DST_ACC));
                    seen = 1'b1;
                end
            end else begin
                exp_q.push_back(op_code(OPS_ACC, OPS_ACC, DST_ACC));
                if (e[i]) exp_q.push_back(op_code(OPS_ACC, OPS_XM, DST_ACC));
            end
        end
        exp_q.push_back(op_code(OPS_ACC, OPS_ONE, DST_ACC));
    endtask

    // Multiplier model plus per-cycle monitor, sampled on the falling edge.
    always @(negedge clock_i) begin
        if (cd == 1) begin
            model_done = 1'b1;
            cd = 0;
        end else begin
            model_done = 1'b0;
            if (cd > 1) cd--;
        end
        if (mul_start_o) begin
            cd = LAT;
            n_starts++;
            last_op = {op_a_sel_o, op_b_sel_o, res_dst_o};
            if (last_op == op_code(OPS_ACC, OPS_ACC, DST_ACC)) saw_square = 1'b1;
            if (exp_q.size() > 0) check("op_seq", last_op, exp_q.pop_front());
            else                  check("op_unexpected", last_op, 7'h7f);
        end
        if (res_we_o) begin
            n_we++;
            check("sel_hold", {op_a_sel_o, op_b_sel_o, res_dst_o}, last_op);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic run_job(input logic [EW-1:0] e, input bit poke);
        int n_exp;
        build_expect(e);
        n_exp    = exp_q.size();
        n_starts = 0;
        n_we     = 0;
        start_i  = 1'b1;
        exp_i    = e;
        @(negedge clock_i);
        start_i  = 1'b0;
        exp_i    = EW'($urandom_range(0, 255));
        check("start_clears_done", done_o, 0);
        check("count_cleared", mul_count_o, 0);
        check("conv_x_issued", mul_start_o, 1);
        check("busy_running", busy_o, 1);
        if (poke) begin
            repeat ($urandom_range(3, 8)) @(negedge clock_i);
            start_i = 1'b1;
            exp_i   = ~e;
            @(negedge clock_i);
            start_i = 1'b0;
        end
        for (int k = 0; k < 3000 && !done_o; k++) @(negedge clock_i);
        check("job_done", done_o, 1);
        check("mul_count", mul_count_o, n_exp);
        check("start_pulses", n_starts, n_exp);
        check("res_we_pulses", n_we, n_exp);
        check("busy_at_done", busy_o, 0);
        check("ops_left", exp_q.size(), 0);
    endtask

    task automatic spurious_done();
        int   we0;
        logic [15:0] cnt0;
        logic done0;
        we0   = n_we;
        cnt0  = mul_count_o;
        done0 = done_o;
        extra_done = 1'b1;
        @(negedge clock_i);
        extra_done = 1'b0;
        repeat (2) @(negedge clock_i);
        check("spurious_done_we", n_we, we0);
        check("spurious_done_count", mul_count_o, cnt0);
        check("spurious_done_state", done_o, done0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, mul_start_o, 0);
        check({tag, "_we"}, res_we_o, 0);
        check({tag, "_busy"}, busy_o, 0);
        check({tag, "_done"}, done_o, 0);
        check({tag, "_count"}, mul_count_o, 0);
        check({tag, "_sels"}, {op_a_sel_o, op_b_sel_o, res_dst_o}, 0);
    endtask

    task automatic reset_mid_square();
        int we0;
        build_expect(8'hFF);
        saw_square = 1'b0;
        start_i = 1'b1;
        exp_i   = 8'hFF;
        @(negedge clock_i);
        start_i = 1'b0;
        for (int k = 0; k < 500 && !saw_square; k++) @(negedge clock_i);
        check("square_reached", saw_square, 1);
        repeat (3) @(negedge clock_i);
        check("in_wait_before_reset", busy_o, 1);
        reset_i = 1'b1;
        #1;
        check_all_zero("async_reset");
        exp_q.delete();
        we0 = n_we;
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;
        for (int k = 0; k < 50 && (cd != 0 || model_done); k++) @(negedge clock_i);
        repeat (2) @(negedge clock_i);
        check("late_done_we", n_we, we0);
        check("late_done_count", mul_count_o, 0);
        check("late_done_idle", busy_o, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        #1;
        check_all_zero("reset");
        check("reset_state", dbg_state_o, IDLE);
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
        @(negedge clock_i);
        spurious_done();
        run_job(8'h05, 1'b0);
        spurious_done();
        run_job(8'h00, 1'b0);
        run_job(8'hFF, 1'b1);
        run_job(8'h80, 1'b0);
        run_job(8'h01, 1'b1);
        reset_mid_square();
        run_job(8'h05, 1'b0);
        for (int j = 0; j < 8; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clock_i);
            run_job(EW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/modexp_control.md
MODEXP_CONTROL -- requirements
Module: modexp_control

Interface
REQ-001 Parameter s, default 8: number of words per operand, passed through to the FIOS datapath.
REQ-002 Parameter EXP_WIDTH, default 8: exponent width in bits, minimum 2.
REQ-003 The clock input SHALL be clock_i, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 The reset input SHALL be reset_i, 1 bit: asynchronous, active-high.
REQ-005 start_i, input, 1: starts a modular exponentiation; sampled only in IDLE or DONE.
REQ-006 exp_i, input, EXP_WIDTH: exponent; captured on an accepted start_i.
REQ-007 mul_done_i, input, 1: completion pulse from the FIOS multiplier.
REQ-008 mul_start_o, output, 1: one-cycle pulse that launches one Montgomery multiplication.
REQ-009 op_a_sel_o and op_b_sel_o, outputs, 3 bits each: operand source codes {ACC, XM, BASE, R2, ONE}.
REQ-010 res_dst_o, output, 1: result destination code {ACC, XM}.
REQ-011 res_we_o, output, 1: one-cycle write strobe to res_dst_o, asserted in the cycle after mul_done_i is accepted.
REQ-012 busy_o, output, 1; done_o, output, 1; mul_count_o, output, 16 bits: number of multiplications issued for the current job.

Function
REQ-013 The FSM SHALL have the states IDLE, CONV_X, CONV_ACC, SQUARE, MULT, NEXT_BIT, FROM_MONT, WAIT and DONE.
REQ-014 Each op state SHALL drive its selects and issue mul_start_o in its first cycle, then go to WAIT.
REQ-015 In WAIT, the FSM SHALL return to the continuation state on mul_done_i, which is remembered in a return register.
REQ-016 The op states SHALL perform the following operations:
- CONV_X: BASE*R2 -> XM
- CONV_ACC: ONE*R2 -> ACC
- SQUARE: ACC*ACC -> ACC
- MULT: ACC*XM -> ACC
- FROM_MONT: ACC*ONE -> ACC
REQ-017 The sequence SHALL be IDLE -> CONV_X -> CONV_ACC, then left-to-right scan from bit EXP_WIDTH-1 down to bit 0.
REQ-018 For each scanned bit, the block SHALL perform SQUARE, then MULT if the bit is 1, then NEXT_BIT.
REQ-019 After bit 0, the sequence SHALL be FROM_MONT -> DONE.
REQ-020 The bit index counter SHALL be $clog2(EXP_WIDTH) bits wide, decrement in NEXT_BIT, and never wrap: NEXT_BIT with index 0 goes to FROM_MONT.
REQ-021 op_a_sel_o, op_b_sel_o and res_dst_o SHALL stay stable from the mul_start_o cycle through the res_we_o cycle.
REQ-022 mul_done_i outside WAIT SHALL be ignored, with no state change and no res_we_o.
REQ-023 start_i while busy_o=1 SHALL be ignored.
REQ-024 start_i in DONE SHALL clear done_o and begin a new job in the next cycle.
REQ-025 busy_o SHALL be 1 in every state except IDLE and DONE.
REQ-026 done_o SHALL be 1 only in DONE and held there until the next start_i.
REQ-027 mul_count_o SHALL clear on an accepted start_i, increment on each mul_start_o, and saturate at 16'hFFFF.
REQ-028 If mul_done_i and mul_start_o coincide, mul_start_o SHALL take precedence; that cannot occur legally, because WAIT is the only state that accepts done.

Reset
REQ-029 Asserting reset_i at any time, including mid-multiplication, SHALL force IDLE immediately.
REQ-030 Under reset_i, the following SHALL all be 0:
- mul_start_o, res_we_o, busy_o, done_o
- mul_count_o, the bit index, the exponent register
- op_a_sel_o, op_b_sel_o, res_dst_o
REQ-031 A mul_done_i arriving after reset release for an aborted operation SHALL be ignored per REQ-022.

Configuration
REQ-032 Macro MODEXP_SKIP_LEADING_ZEROS_EN: when defined, the scan SHALL skip every SQUARE and MULT until the first 1 bit.
REQ-033 With MODEXP_SKIP_LEADING_ZEROS_EN defined, the first 1 bit SHALL issue MULT only, with no SQUARE.
REQ-034 With MODEXP_SKIP_LEADING_ZEROS_EN defined, exp_i = 0 SHALL go CONV_ACC -> FROM_MONT directly.
REQ-035 When MODEXP_SKIP_LEADING_ZEROS_EN is undefined, all EXP_WIDTH bits SHALL be processed per REQ-017 to REQ-019.

Structure
REQ-036 The operand select codes, destination codes and state enum SHALL reside in the shared package fios_pkg:
- operand selects: OPS_ACC=0, OPS_XM=1, OPS_BASE=2, OPS_R2=3, OPS_ONE=4
- destinations: DST_ACC=0, DST_XM=1
REQ-037 The exponent shift/index logic SHALL be one sub-module, exp_bit_scanner, providing current bit, last-bit flag and first-one-seen flag; everything else is flat.

Verification
REQ-038 EXP_WIDTH=8, macro off, exp_i=8'h05, with the multiplier model asserting done 10 cycles after start: the bench SHALL observe 13 mul_start_o pulses, in the order CONV_X, CONV_ACC, 5xSQUARE, SQUARE, MULT, SQUARE, SQUARE, MULT, FROM_MONT; mul_count_o=13; done_o=1.
REQ-039 Macro on, exp_i=8'h05: the bench SHALL observe 7 pulses, in the order CONV_X, CONV_ACC, MULT, SQUARE, SQUARE, MULT, FROM_MONT.
REQ-040 Macro on, exp_i=0: the bench SHALL observe 3 pulses, then done_o=1.
REQ-041 reset_i asserted while in WAIT during SQUARE: outputs SHALL be 0 within the same cycle.
REQ-042 After REQ-041, a late mul_done_i followed by start_i SHALL run a clean, complete job.
REQ-043 Spurious mul_done_i in IDLE or DONE, and start_i pulses in WAIT, SHALL cause no res_we_o and no change to mul_count_o.
REQ-044 A back-to-back start_i while in DONE SHALL clear done_o next cycle, reset mul_count_o to 0, and issue CONV_X.
